// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared loader state encoding and instruction memory sizing
package imem_loader_pkg;

  localparam int DATA_BITS_DEF = 32;
  localparam int IMEM_SIZE_DEF = 128;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

endpackage

// File: rtl/imem_word_packer.sv
// rtl/imem_word_packer.sv - big-endian byte to word assembler
module imem_word_packer #(
  parameter int WORD_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           byte_in,
  input  logic                 accept,
  input  logic                 clear,
  output logic [WORD_BITS-1:0] word,
  output logic                 word_valid
);

  localparam int NBYTES = WORD_BITS / 8;
  localparam int CW     = $clog2(NBYTES);

  // Only the bytes already received are stored; the current byte completes the word.
  logic [WORD_BITS-9:0] shreg;
  logic [CW-1:0]        cnt;

  assign word       = {shreg, byte_in};
  assign word_valid = accept && (cnt == CW'(NBYTES - 1));

  // Shift accepted bytes in from the bottom so the first byte lands in the top lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clear) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (accept) begin
      shreg <= word[WORD_BITS-9:0];
      cnt   <= word_valid ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte stream to instruction memory loader with CPU hold
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int IMEM_SIZE = IMEM_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 imem_we,
  output logic [DATA_BITS-1:0] imem_addr,
  output logic [DATA_BITS-1:0] imem_wdata,
  output logic                 cpu_hold,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  state_t               state, state_nxt;
  logic [15:0]          len;
  logic [15:0]          full_len;
  logic [DATA_BITS-1:0] word_cnt;
  logic [DATA_BITS-1:0] word;
  logic                 accept;
  logic                 pk_accept;
  logic                 pk_clear;
  logic                 word_valid;
  logic                 last_word;

  assign accept    = byte_valid && byte_ready;
  assign pk_accept = accept && (state == S_DATA);
  assign pk_clear  = accept && (state == S_LEN_LO);
  assign full_len  = {len[15:8], byte_in};
  assign last_word = (word_cnt == (DATA_BITS'(len) - DATA_BITS'(1)));

  // Status flags are pure decodes of the state, so they track it without lag.
  assign busy     = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA);
  assign done     = (state == S_DONE);
  assign error    = (state == S_ERROR);
  assign cpu_hold = (state != S_DONE);

  imem_word_packer #(.WORD_BITS(DATA_BITS)) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_in    (byte_in),
    .accept     (pk_accept),
    .clear      (pk_clear),
    .word       (word),
    .word_valid (word_valid)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and byte handshake; start is only honoured when not busy.
  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          if (full_len == 16'd0)                 state_nxt = S_DONE;
          else if (full_len > 16'(IMEM_SIZE))   state_nxt = S_ERROR;
          else                                  state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        byte_ready = 1'b1;
        if (word_valid && last_word) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Length capture, word counting and the registered memory write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len        <= '0;
      word_cnt   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      if (accept && (state == S_LEN_HI)) begin
        len[15:8] <= byte_in;
      end
      if (pk_clear) begin
        len      <= full_len;
        word_cnt <= '0;
      end
      if (word_valid) begin
        imem_we    <= 1'b1;
        imem_addr  <= word_cnt;
        imem_wdata <= word;
        word_cnt   <= word_cnt + DATA_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;
  logic [63:0] wq[$];

  imem_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Record every write pulse seen by the memory side.
  always @(negedge clk) if (rst_n && imem_we) wq.push_back({imem_addr, imem_wdata});

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: back-to-back, 1: one idle cycle between bytes, 2: random idle gaps
  task automatic send_byte(input logic [7:0] b, input int mode);
    int n;
    int gap;
    logic acc;
    gap = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
    repeat (gap) begin @(posedge clk); #1; end
    byte_in    = b;
    byte_valid = 1'b1;
    n = 0;
    forever begin
      acc = byte_ready;
      @(posedge clk); #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        total++; bad++;
        $display("FAIL byte_timeout: got no accept expected accept within 200 cycles");
        break;
      end
    end
    byte_valid = 1'b0;
    byte_in    = $urandom;
  endtask

  typedef struct {
    int len;
    int mode;
    bit mid_start;
    bit exp_done;
    bit exp_err;
    int exp_writes;
  } row_t;

  row_t rows[9];

  initial begin
    logic [7:0]  data[$];
    logic [31:0] exp_word;
    int          nw;
    int          rl;

    // Reset state while rst_n is held low.
    repeat (2) @(posedge clk); #1;
    check("rst_cpu_hold",   64'(cpu_hold),   64'd1);
    check("rst_busy",       64'(busy),       64'd0);
    check("rst_done",       64'(done),       64'd0);
    check("rst_error",      64'(error),      64'd0);
    check("rst_byte_ready", 64'(byte_ready), 64'd0);
    check("rst_imem_we",    64'(imem_we),    64'd0);
    check("rst_addr",       64'(imem_addr),  64'd0);
    check("rst_wdata",      64'(imem_wdata), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Bytes offered while idle must not be taken.
    byte_valid = 1'b1;
    check("idle_byte_ready", 64'(byte_ready), 64'd0);
    byte_valid = 1'b0;

    rl = $urandom_range(3, 127);
    //        len     mode mid  done err writes
    rows[0] = '{2,      0, 0,   1,   0,  2};
    rows[1] = '{2,      1, 0,   1,   0,  2};
    rows[2] = '{129,    0, 0,   0,   1,  0};
    rows[3] = '{0,      0, 0,   1,   0,  0};
    rows[4] = '{256,    0, 0,   0,   1,  0};
    rows[5] = '{128,    0, 0,   1,   0,  128};
    rows[6] = '{5,      2, 1,   1,   0,  5};
    rows[7] = '{rl,     2, 0,   1,   0,  rl};
    rows[8] = '{1,      0, 1,   1,   0,  1};

    foreach (rows[r]) begin
      nw = (rows[r].len <= 128) ? rows[r].len : 0;
      data.delete();
      if (r == 0) data = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      else for (int i = 0; i < 4 * nw; i++) data.push_back(8'($urandom));

      wq.delete();
      pulse_start();
      check($sformatf("r%0d_start_busy", r), 64'(busy), 64'd1);
      check($sformatf("r%0d_start_hold", r), 64'(cpu_hold), 64'd1);

      send_byte(8'(rows[r].len >> 8), rows[r].mode);
      send_byte(8'(rows[r].len), rows[r].mode);
      foreach (data[i]) begin
        send_byte(data[i], rows[r].mode);
        if (rows[r].mid_start && i == 1) pulse_start();
      end

      // One cycle after the final accepted byte.
      check($sformatf("r%0d_done", r),  64'(done),       64'(rows[r].exp_done));
      check($sformatf("r%0d_error", r), 64'(error),      64'(rows[r].exp_err));
      check($sformatf("r%0d_hold", r),  64'(cpu_hold),   64'(!rows[r].exp_done));
      check($sformatf("r%0d_busy", r),  64'(busy),       64'd0);
      check($sformatf("r%0d_ready", r), 64'(byte_ready), 64'd0);
      if (nw > 0) check($sformatf("r%0d_last_we", r), 64'(imem_we), 64'd1);

      repeat (2) begin @(posedge clk); #1; end
      check($sformatf("r%0d_nwrites", r), 64'(wq.size()), 64'(rows[r].exp_writes));
      for (int i = 0; i < nw && i < wq.size(); i++) begin
        exp_word = {data[4*i], data[4*i+1], data[4*i+2], data[4*i+3]};
        check($sformatf("r%0d_w%0d", r, i), wq[i], {32'(i), exp_word});
      end
      check($sformatf("r%0d_sticky", r), 64'({done, error}),
            64'({rows[r].exp_done, rows[r].exp_err}));
    end

    // Restart from DONE: hold reasserts on start and a one-word image overwrites addr 0.
    wq.delete();
    pulse_start();
    check("rs_hold_on_start", 64'(cpu_hold), 64'd1);
    check("rs_done_cleared",  64'(done),     64'd0);
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0);
    check("rs_hold_before_write", 64'(cpu_hold), 64'd1);
    send_byte(8'hDD, 0);
    check("rs_done", 64'(done), 64'd1);
    check("rs_hold_released", 64'(cpu_hold), 64'd0);
    @(posedge clk); #1;
    check("rs_nwrites", 64'(wq.size()), 64'd1);
    if (wq.size() > 0) check("rs_word", wq[0], {32'd0, 32'hAABBCCDD});

    // Asynchronous reset mid-load, landing on a write pulse.
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 0); send_byte(8'h78, 0);
    check("mr_we_before", 64'(imem_we), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mr_imem_we",    64'(imem_we),    64'd0);
    check("mr_cpu_hold",   64'(cpu_hold),   64'd1);
    check("mr_done",       64'(done),       64'd0);
    check("mr_error",      64'(error),      64'd0);
    check("mr_byte_ready", 64'(byte_ready), 64'd0);
    check("mr_busy",       64'(busy),       64'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mr_idle_ready", 64'(byte_ready), 64'd0);
    check("mr_idle_hold",  64'(cpu_hold),   64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
